// File: rtl/wb_retire_queue_if.sv
// Result-bundle input and register-file write output bus of wb_retire_queue.
interface wb_retire_queue_if #(
    parameter int LANES  = 2,
    parameter int WPORTS = 1,
    parameter int DW     = 32,
    parameter int RW     = 5
);
    logic [LANES-1:0]     in_valid;
    logic [LANES*RW-1:0]  in_rd;
    logic [LANES*DW-1:0]  in_data;
    logic                 in_halt;
    logic                 stall;
    logic                 flush;
    logic                 in_ready;
    logic [WPORTS-1:0]    wen;
    logic [WPORTS*RW-1:0] wsel;
    logic [WPORTS*DW-1:0] wdat;

    modport master (
        output in_valid, in_rd, in_data, in_halt, stall, flush,
        input  in_ready, wen, wsel, wdat
    );

    modport slave (
        input  in_valid, in_rd, in_data, in_halt, stall, flush,
        output in_ready, wen, wsel, wdat
    );
endinterface

// File: rtl/wb_retire_queue.sv
// In-order multi-lane writeback retire queue with pending-write forwarding.
// Optional macro WB_BYPASS_EN: bundles arriving at an empty queue that fit the write ports skip it.
module wb_retire_queue #(
    parameter int LANES  = 2,
    parameter int WPORTS = 1,
    parameter int DEPTH  = 8,
    parameter int DW     = 32,
    parameter int RW     = 5
) (
    input  logic                   CLK,
    input  logic                   RST,
    wb_retire_queue_if.slave       bus,
    input  logic [RW-1:0]          fwd_reg,
    output logic                   fwd_hit,
    output logic [DW-1:0]          fwd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   halt_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } entry_t;
    typedef logic [WPORTS-1:0][RW-1:0] sel_t;
    typedef logic [WPORTS-1:0][DW-1:0] dat_t;

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              halt_pend_q, halt_pend_d, halt_q, halt_d;
    logic [WPORTS-1:0] wen_q, wen_d;
    sel_t              wsel_q, wsel_d;
    dat_t              wdat_q, wdat_d;

    logic              ready, accept, bypass;
    logic [LANES-1:0]  live;
    logic [CW-1:0]     slot [LANES];
    logic [CW-1:0]     nlive, enq, deq, ndrain;
    logic [WPORTS-1:0] grp_vld;

    // Within one write group only the youngest write to a given register may fire.
    function automatic logic [WPORTS-1:0] keep_youngest(input logic [WPORTS-1:0] vld, input sel_t rd);
        logic [WPORTS-1:0] keep;
        keep = vld;
        for (int p = 0; p < WPORTS; p++)
            for (int q = p + 1; q < WPORTS; q++)
                if (vld[q] && rd[q] == rd[p]) keep[p] = 1'b0;
        return keep;
    endfunction

    assign ready  = (CW'(DEPTH) - count_q) >= CW'(LANES);
    assign accept = ready && !bus.stall && !bus.flush;

    // NOTE: always_comb uses blocking '=' so each statement sees the value computed just above it.
    always_comb begin
        nlive = '0;
        for (int l = 0; l < LANES; l++) begin
            live[l] = bus.in_valid[l] && (bus.in_rd[l*RW +: RW] != '0);
            slot[l] = nlive;
            if (live[l]) nlive = nlive + CW'(1);
        end
    end

`ifdef WB_BYPASS_EN
    logic [WPORTS-1:0] byp_vld;
    sel_t              byp_rd;
    dat_t              byp_dat;

    assign bypass = accept && (count_q == '0) && (nlive <= CW'(WPORTS));

    always_comb begin
        byp_vld = '0;
        byp_rd  = '0;
        byp_dat = '0;
        for (int p = 0; p < WPORTS; p++)
            for (int l = 0; l < LANES; l++)
                if (live[l] && slot[l] == CW'(p)) begin
                    byp_vld[p] = 1'b1;
                    byp_rd[p]  = bus.in_rd[l*RW +: RW];
                    byp_dat[p] = bus.in_data[l*DW +: DW];
                end
    end

    assign bus.wen  = bypass ? keep_youngest(byp_vld, byp_rd) : wen_q;
    assign bus.wsel = bypass ? byp_rd  : wsel_q;
    assign bus.wdat = bypass ? byp_dat : wdat_q;
`else
    assign bypass   = 1'b0;
    assign bus.wen  = wen_q;
    assign bus.wsel = wsel_q;
    assign bus.wdat = wdat_q;
`endif

    // The write register holds the oldest min(count, WPORTS) entries; they retire at the edge they leave it.
    always_comb begin
        // NOTE: every signal gets a default before any conditional update, so no latch is inferred.
        deq     = (count_q < CW'(WPORTS)) ? count_q : CW'(WPORTS);
        enq     = (accept && !bypass) ? nlive : '0;
        head_d  = head_q + deq[AW-1:0];
        tail_d  = tail_q + enq[AW-1:0];
        count_d = count_q + enq - deq;
        mem_d   = mem_q;
        if (accept && !bypass)
            for (int l = 0; l < LANES; l++)
                if (live[l])
                    mem_d[tail_q + slot[l][AW-1:0]] = '{rd: bus.in_rd[l*RW +: RW], data: bus.in_data[l*DW +: DW]};

        ndrain  = (count_d < CW'(WPORTS)) ? count_d : CW'(WPORTS);
        grp_vld = '0;
        wsel_d  = '0;
        wdat_d  = '0;
        for (int p = 0; p < WPORTS; p++)
            if (CW'(p) < ndrain) begin
                grp_vld[p] = 1'b1;
                wsel_d[p]  = mem_d[head_d + AW'(p)].rd;
                wdat_d[p]  = mem_d[head_d + AW'(p)].data;
            end
        wen_d = keep_youngest(grp_vld, wsel_d);

        halt_pend_d = halt_pend_q || (accept && bus.in_halt);
        halt_d      = halt_q || (halt_pend_q && count_q == '0);
    end

    // Walk oldest to youngest so the youngest match overrides.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++)
            if (CW'(i) < count_q && fwd_reg != '0 && mem_q[head_q + AW'(i)].rd == fwd_reg) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_q[head_q + AW'(i)].data;
            end
    end

    // NOTE: state flops use non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            halt_pend_q <= 1'b0;
            halt_q      <= 1'b0;
            wen_q       <= '0;
            wsel_q      <= '0;
            wdat_q      <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            halt_pend_q <= halt_pend_d;
            halt_q      <= halt_d;
            wen_q       <= wen_d;
            wsel_q      <= wsel_d;
            wdat_q      <= wdat_d;
        end
    end

    // NOTE: queue storage has no reset; count_q alone decides which entries are live.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign bus.in_ready = ready;
    assign count        = count_q;
    assign halt_out     = halt_q;
endmodule

// File: tb/tb_wb_retire_queue.sv
// Bench for wb_retire_queue: WPORTS=1 and WPORTS=2 instances share stimulus and are
// compared every cycle against a queue-of-results reference model.
module tb_wb_retire_queue;
    localparam int LANES = 2;
    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int RW    = 5;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic [1:0]    t_valid;
    logic [RW-1:0] t_rd   [2];
    logic [DW-1:0] t_data [2];
    logic          t_halt, t_stall, t_flush;
    logic [RW-1:0] t_fwd;

    wb_retire_queue_if #(.LANES(LANES), .WPORTS(1), .DW(DW), .RW(RW)) bus0 ();
    wb_retire_queue_if #(.LANES(LANES), .WPORTS(2), .DW(DW), .RW(RW)) bus1 ();

    assign bus0.in_valid = t_valid;
    assign bus0.in_rd    = {t_rd[1], t_rd[0]};
    assign bus0.in_data  = {t_data[1], t_data[0]};
    assign bus0.in_halt  = t_halt;
    assign bus0.stall    = t_stall;
    assign bus0.flush    = t_flush;
    assign bus1.in_valid = t_valid;
    assign bus1.in_rd    = {t_rd[1], t_rd[0]};
    assign bus1.in_data  = {t_data[1], t_data[0]};
    assign bus1.in_halt  = t_halt;
    assign bus1.stall    = t_stall;
    assign bus1.flush    = t_flush;

    logic          fwd_hit_o  [2];
    logic [DW-1:0] fwd_data_o [2];
    logic [3:0]    count_o    [2];
    logic          halt_o     [2];
    logic          ready_o    [2];
    logic [1:0]    wen_o      [2];
    logic [RW-1:0] wsel_o     [2][2];
    logic [DW-1:0] wdat_o     [2][2];

    wb_retire_queue #(.LANES(LANES), .WPORTS(1), .DEPTH(DEPTH), .DW(DW), .RW(RW)) dut0 (
        .CLK(CLK), .RST(RST), .bus(bus0), .fwd_reg(t_fwd), .fwd_hit(fwd_hit_o[0]),
        .fwd_data(fwd_data_o[0]), .count(count_o[0]), .halt_out(halt_o[0])
    );
    wb_retire_queue #(.LANES(LANES), .WPORTS(2), .DEPTH(DEPTH), .DW(DW), .RW(RW)) dut1 (
        .CLK(CLK), .RST(RST), .bus(bus1), .fwd_reg(t_fwd), .fwd_hit(fwd_hit_o[1]),
        .fwd_data(fwd_data_o[1]), .count(count_o[1]), .halt_out(halt_o[1])
    );

    assign ready_o[0]   = bus0.in_ready;
    assign ready_o[1]   = bus1.in_ready;
    assign wen_o[0]     = {1'b0, bus0.wen};
    assign wen_o[1]     = bus1.wen;
    assign wsel_o[0][0] = bus0.wsel;
    assign wsel_o[0][1] = '0;
    assign wdat_o[0][0] = bus0.wdat;
    assign wdat_o[0][1] = '0;
    assign wsel_o[1][0] = bus1.wsel[RW-1:0];
    assign wsel_o[1][1] = bus1.wsel[2*RW-1:RW];
    assign wdat_o[1][0] = bus1.wdat[DW-1:0];
    assign wdat_o[1][1] = bus1.wdat[2*DW-1:DW];

    // Reference model: pending results per instance, oldest at index 0.
    typedef struct {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mq [2][$];
    bit   mpend [2];
    bit   mhalt [2];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int wp(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // The write group on the ports is the oldest min(pending, WPORTS) results, still pending.
    task automatic check_outputs();
        int            sz, n;
        logic          ew, exp_hit;
        logic [DW-1:0] exp_fd;
        for (int i = 0; i < 2; i++) begin
            sz = mq[i].size();
            n  = (sz < wp(i)) ? sz : wp(i);
            check($sformatf("u%0d.count", i), 64'(count_o[i]), 64'(sz));
            check($sformatf("u%0d.in_ready", i), 64'(ready_o[i]), 64'((DEPTH - sz) >= LANES));
            for (int p = 0; p < wp(i); p++) begin
                ew = (p < n);
                for (int q = p + 1; q < n; q++)
                    if (mq[i][q].rd == mq[i][p].rd) ew = 1'b0;
                check($sformatf("u%0d.wen%0d", i, p), 64'(wen_o[i][p]), 64'(ew));
                if (ew) begin
                    check($sformatf("u%0d.wsel%0d", i, p), 64'(wsel_o[i][p]), 64'(mq[i][p].rd));
                    check($sformatf("u%0d.wdat%0d", i, p), 64'(wdat_o[i][p]), 64'(mq[i][p].data));
                end
            end
            exp_hit = 1'b0;
            exp_fd  = '0;
            for (int k = 0; k < sz; k++)
                if (t_fwd != '0 && mq[i][k].rd == t_fwd) begin
                    exp_hit = 1'b1;
                    exp_fd  = mq[i][k].data;
                end
            check($sformatf("u%0d.fwd_hit", i), 64'(fwd_hit_o[i]), 64'(exp_hit));
            if (exp_hit || t_fwd == '0)
                check($sformatf("u%0d.fwd_data", i), 64'(fwd_data_o[i]), 64'(exp_fd));
            check($sformatf("u%0d.halt_out", i), 64'(halt_o[i]), 64'(mhalt[i]));
        end
    endtask

    task automatic model_update();
        int   sz;
        bit   acc;
        ent_t e;
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                mq[i].delete();
                mpend[i] = 1'b0;
                mhalt[i] = 1'b0;
            end else begin
                sz  = mq[i].size();
                acc = ((DEPTH - sz) >= LANES) && !t_stall && !t_flush;
                mhalt[i] = mhalt[i] || (mpend[i] && sz == 0);
                mpend[i] = mpend[i] || (acc && t_halt);
                repeat ((sz < wp(i)) ? sz : wp(i)) void'(mq[i].pop_front());
                if (acc)
                    for (int l = 0; l < LANES; l++)
                        if (t_valid[l] && t_rd[l] != '0) begin
                            e.rd   = t_rd[l];
                            e.data = t_data[l];
                            mq[i].push_back(e);
                        end
            end
        end
    endtask

    // Inputs change 1 ns after the edge; outputs are checked on the falling edge.
    task automatic cycle();
        @(negedge CLK);
        check_outputs();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic bundle(input logic [1:0] v, input logic [RW-1:0] r0, input logic [DW-1:0] d0,
                          input logic [RW-1:0] r1, input logic [DW-1:0] d1);
        t_valid   = v;
        t_rd[0]   = r0;
        t_data[0] = d0;
        t_rd[1]   = r1;
        t_data[1] = d1;
        cycle();
        t_valid = 2'b00;
        t_halt  = 1'b0;
    endtask

    task automatic idle(input int n);
        t_valid = 2'b00;
        repeat (n) cycle();
    endtask

    initial begin
        RST = 1'b1;
        t_valid = 2'b00; t_halt = 1'b0; t_stall = 1'b0; t_flush = 1'b0; t_fwd = '0;
        t_rd[0] = '0; t_rd[1] = '0; t_data[0] = '0; t_data[1] = '0;
        @(posedge CLK);
        model_update();
        #1;
        cycle();
        RST = 1'b0;

        // Basic two-lane bundle, drained over two cycles on the single-port instance.
        bundle(2'b11, 5'd3, 32'h11, 5'd4, 32'h22);
        idle(4);

        // Back-to-back full bundles: the single-port queue fills and deasserts in_ready.
        for (int c = 0; c < 8; c++)
            bundle(2'b11, 5'(1 + 2*c), $urandom, 5'(2 + 2*c), $urandom);
        idle(10);

        // Same destination twice in one bundle.
        bundle(2'b11, 5'd5, 32'hAA, 5'd5, 32'hBB);
        idle(3);

        // Forwarding: youngest pending r7 wins; r0 never hits.
        t_fwd = 5'd7;
        bundle(2'b11, 5'd7, 32'h1, 5'd7, 32'h2);
        cycle();
        t_fwd = 5'd0;
        idle(3);

        // Flushed bundle and rd=0 bundle enqueue nothing.
        t_flush = 1'b1;
        bundle(2'b11, 5'd9, 32'h99, 5'd10, 32'hA0);
        t_flush = 1'b0;
        bundle(2'b11, 5'd0, 32'h55, 5'd0, 32'h66);
        idle(2);

        // Halt with three pending results, then a post-halt bundle still drains.
        bundle(2'b11, 5'd1, 32'hC1, 5'd2, 32'hC2);
        t_halt = 1'b1;
        bundle(2'b01, 5'd3, 32'hC3, 5'd0, 32'h0);
        idle(7);
        bundle(2'b11, 5'd4, 32'hD4, 5'd6, 32'hD6);
        idle(1);

        // Reset in the middle of a drain discards everything.
        bundle(2'b11, 5'd8, 32'hE8, 5'd9, 32'hE9);
        bundle(2'b11, 5'd10, 32'hEA, 5'd11, 32'hEB);
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        idle(2);

        // Randomized traffic with narrow register range to provoke collisions.
        for (int c = 0; c < 600; c++) begin
            t_valid   = 2'($urandom_range(0, 3));
            t_rd[0]   = 5'($urandom_range(0, 7));
            t_rd[1]   = 5'($urandom_range(0, 7));
            t_data[0] = $urandom;
            t_data[1] = $urandom;
            t_stall   = ($urandom_range(0, 4) == 0);
            t_flush   = ($urandom_range(0, 9) == 0);
            t_halt    = ($urandom_range(0, 40) == 0);
            t_fwd     = 5'($urandom_range(0, 7));
            RST       = ($urandom_range(0, 99) == 0);
            cycle();
        end
        RST = 1'b0; t_stall = 1'b0; t_flush = 1'b0; t_halt = 1'b0;
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_retire_queue.md
Name: wb_retire_queue

Overview:
- Parametrised successor to the single-lane writeback stage.
- Accepts up to LANES retiring results per cycle from the memory/writeback boundary.
- Buffers them in an in-order circular queue and drains up to WPORTS register-file writes per cycle.
- Provides a forwarding lookup for still-pending writes, so a register file with fewer write ports than pipeline lanes never loses a result.

Parameters:
- LANES, 2, number of results presented per cycle.
- WPORTS, 1, number of register-file write ports drained per cycle (1..LANES).
- DEPTH, 8, queue entries; power of 2, DEPTH >= 2*LANES.
- DW, 32, data word width.
- RW, 5, register index width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  LANES  per-lane result valid; lane 0 oldest.
- in_rd  in  LANES*RW  per-lane destination register.
- in_data  in  LANES*DW  per-lane result data.
- in_halt  in  1  halt retiring with this bundle.
- stall  in  1  upstream stall: bundle not presented this cycle.
- flush  in  1  discard bundle this cycle.
- in_ready  out  1  queue can accept a full bundle.
- wen  out  WPORTS  register-file write enables.
- wsel  out  WPORTS*RW  write register indices.
- wdat  out  WPORTS*DW  write data.
- fwd_reg  in  RW  forwarding query register.
- fwd_hit  out  1  query matches a pending entry.
- fwd_data  out  DW  data of youngest matching entry.
- count  out  log2(DEPTH)+1  occupied entries.
- halt_out  out  1  sticky halt, all prior results written.

Behaviour:
- Reset state: head=0, tail=0, count=0, wen=0, wsel=0, wdat=0, fwd_hit=0, halt_out=0, halt-pending flag cleared. in_ready=1 from the first cycle after reset. Reset mid-operation discards all pending entries with no writes issued.
- in_ready is combinational: (DEPTH-count) >= LANES, using the current count only. Same-cycle drains do not add space.
- Accept condition: in_ready && !stall && !flush. When accepted, lanes with in_valid=1 and in_rd!=0 are compacted in lane order and written at tail..tail+k-1 (mod DEPTH). Lanes with rd=0 are dropped silently.
- When accept is false, nothing is enqueued and no in_halt is latched. The upstream is responsible for holding the bundle.
- Drain: each cycle, min(count, WPORTS) oldest entries are issued on ports 0..n-1 in age order. Port p gets head+p. wen/wsel/wdat are registered, so an entry enqueued in cycle N is written at the earliest in cycle N+1.
- Same-rd collision within one drain group: older port's wen is suppressed; only the youngest write reaches the register file.
- Pointer arithmetic is modulo DEPTH. count_next = count + enq - deq. Simultaneous enqueue and dequeue are legal, including at full and empty.
- Forwarding is combinational over stored entries not yet drained, including entries presented on wen this cycle. The youngest match wins. fwd_reg=0 forces fwd_hit=0 and fwd_data=0.
- Halt: an accepted in_halt sets halt-pending. When halt-pending and count==0, halt_out rises on the next edge and stays high until RST.
- Bundles accepted after the halt are still queued and drained. Behaviour is defined, but the core never issues them.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: if count==0 and the accepted non-zero-rd lanes number <= WPORTS, those results bypass the queue and drive wen/wsel/wdat combinationally in the same cycle, giving zero latency. They are not enqueued and count is unchanged.
- Not defined: fixed 1-cycle minimum latency; all results go through the queue.

Test Plan:
- LANES=2, WPORTS=1: one bundle {r3=0x11, r4=0x22} -> write r3=0x11 at cycle N+1, r4=0x22 at N+2; count 2→1→0.
- Back-to-back full bundles with no stall for 8 cycles (DEPTH=8) -> in_ready drops when count reaches 7. No result is lost and writes occur in exact lane/cycle order.
- Bundle {r5=0xAA, r5=0xBB} with WPORTS=2 -> single write r5=0xBB; port 0 wen=0.
- Pending r7=0x1 then r7=0x2 with fwd_reg=7 -> fwd_hit=1, fwd_data=0x2. fwd_reg=0 -> fwd_hit=0.
- flush=1 with valid bundle, and a bundle with rd=0 -> no enqueue, count unchanged, no wen.
- in_halt with 3 pending entries -> halt_out=1 one cycle after the last write. Assert RST mid-drain -> wen=0 and count=0 the following cycle.
